// File: rtl/jump_pkg.sv
// Shared definitions for the ID-stage jump target unit: JumpType encodings.
package jump_pkg;

  localparam logic [1:0] JT_NONE = 2'b00;
  localparam logic [1:0] JT_J    = 2'b01;
  localparam logic [1:0] JT_JAL  = 2'b10;
  localparam logic [1:0] JT_JR   = 2'b11;

endpackage : jump_pkg

// File: rtl/jump_target_unit_if.sv
// ID-stage decode bus into the jump target unit and its registered results back out.
interface jump_target_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_WIDTH  = 26
);

  logic                  Stall;
  logic                  Flush;
  logic                  Valid_in;
  logic [1:0]            JumpType;
  logic [ADDR_WIDTH-1:0] PCAddResult;
  logic [IDX_WIDTH-1:0]  Instruction_idx;
  logic [ADDR_WIDTH-1:0] RegRs;

  logic [ADDR_WIDTH-1:0] Address;
  logic                  Redirect;
  logic                  RASMispredict;
  logic                  RASEmpty;
  logic                  RASOverflow;

  // Decode side drives the request and consumes the redirect.
  modport master (
    output Stall, Flush, Valid_in, JumpType, PCAddResult, Instruction_idx, RegRs,
    input  Address, Redirect, RASMispredict, RASEmpty, RASOverflow
  );

  modport slave (
    input  Stall, Flush, Valid_in, JumpType, PCAddResult, Instruction_idx, RegRs,
    output Address, Redirect, RASMispredict, RASEmpty, RASOverflow
  );

endinterface : jump_target_unit_if

// File: rtl/ras_stack.sv
// Circular return-address stack with a saturating occupancy count; the oldest
// entry is silently overwritten when a push arrives while full.
module ras_stack #(
  parameter int RAS_DEPTH  = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] push_data,
  output logic [ADDR_WIDTH-1:0] top_data,
  output logic                  empty,
  output logic                  full
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ras_stack: RAS_DEPTH must be a power of two and >= 2");
  end

  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [ADDR_WIDTH-1:0] entries_q [RAS_DEPTH];

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(RAS_DEPTH));
  assign top_data = entries_q[ptr_q];

  // Pointer arithmetic wraps naturally because the depth is a power of two.
  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    if (push) begin
      ptr_d = ptr_q + 1'b1;
      if (!full) count_d = count_q + 1'b1;
    end else if (pop && !empty) begin
      ptr_d   = ptr_q - 1'b1;
      count_d = count_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // NOTE: entry storage is deliberately not reset; count gates every read, so contents are don't-care.
  always_ff @(posedge clk) begin
    if (push) entries_q[ptr_d] <= push_data;
  end

endmodule : ras_stack

// File: rtl/jump_target_unit.sv
// Registered J/JAL/JR target generator for the ID stage, with a return-address
// stack that checks each JR against the most recent JAL link address.
module jump_target_unit
  import jump_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_WIDTH  = 26,
  parameter int RAS_DEPTH  = 4
) (
  input  logic            Clk,
  input  logic            Reset,
  jump_target_unit_if.slave jt
);

  if (ADDR_WIDTH < IDX_WIDTH + 2) begin : g_bad_width
    $error("jump_target_unit: ADDR_WIDTH must be >= IDX_WIDTH+2");
  end

  logic                  accept;
  logic                  is_jal;
  logic                  is_jr;
  logic                  ras_push;
  logic                  ras_pop;
  logic                  ras_empty;
  logic                  ras_full;
  logic [ADDR_WIDTH-1:0] ras_top;
  logic [ADDR_WIDTH-1:0] j_target;

  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic                  redirect_q, redirect_d;
  logic                  mispredict_q, mispredict_d;
  logic                  overflow_q, overflow_d;

  // Stall gates accept, so a stalled jump never touches the stack either.
  assign accept   = jt.Valid_in & ~jt.Flush & ~jt.Stall & (jt.JumpType != JT_NONE);
  assign is_jal   = (jt.JumpType == JT_JAL);
  assign is_jr    = (jt.JumpType == JT_JR);
  assign ras_push = accept & is_jal;
  assign ras_pop  = accept & is_jr & ~ras_empty;

  if (ADDR_WIDTH > IDX_WIDTH + 2) begin : g_target_upper
    assign j_target = {jt.PCAddResult[ADDR_WIDTH-1:IDX_WIDTH+2], jt.Instruction_idx, 2'b00};
  end else begin : g_target_exact
    assign j_target = {jt.Instruction_idx, 2'b00};
  end

  ras_stack #(
    .RAS_DEPTH (RAS_DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ras (
    .clk      (Clk),
    .rst_n    (Reset),
    .push     (ras_push),
    .pop      (ras_pop),
    .push_data(jt.PCAddResult),
    .top_data (ras_top),
    .empty    (ras_empty),
    .full     (ras_full)
  );

  // NOTE: every variable assigned here gets a default first so no latch is inferred.
  always_comb begin
    address_d    = address_q;
    redirect_d   = redirect_q;
    mispredict_d = mispredict_q;
    overflow_d   = overflow_q;
    if (!jt.Stall) begin
      redirect_d   = accept;
      mispredict_d = 1'b0;
      if (accept) address_d = is_jr ? jt.RegRs : j_target;
      // An empty stack has no prediction, which counts as a miss.
      if (accept && is_jr) mispredict_d = ras_empty | (ras_top != jt.RegRs);
      if (ras_push && ras_full) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      address_q    <= '0;
      redirect_q   <= 1'b0;
      mispredict_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      address_q    <= address_d;
      redirect_q   <= redirect_d;
      mispredict_q <= mispredict_d;
      overflow_q   <= overflow_d;
    end
  end

  assign jt.Address       = address_q;
  assign jt.Redirect      = redirect_q;
  assign jt.RASMispredict = mispredict_q;
  assign jt.RASEmpty      = ras_empty;
  assign jt.RASOverflow   = overflow_q;

endmodule : jump_target_unit

// File: tb/tb_jump_target_unit.sv
// Directed self-checking bench for jump_target_unit: J/JAL/JR targets, RAS
// push/pop/overflow/mispredict, stall and flush handling, asynchronous reset.
module tb_jump_target_unit;
  import jump_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  jump_target_unit_if #(.ADDR_WIDTH(32), .IDX_WIDTH(26)) jt_if ();

  jump_target_unit #(
    .ADDR_WIDTH(32),
    .IDX_WIDTH (26),
    .RAS_DEPTH (4)
  ) dut (
    .Clk  (clk),
    .Reset(rst_n),
    .jt   (jt_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] jtype, input logic [31:0] pc,
                       input logic [25:0] idx, input logic [31:0] rs);
    jt_if.Valid_in        = 1'b1;
    jt_if.JumpType        = jtype;
    jt_if.PCAddResult     = pc;
    jt_if.Instruction_idx = idx;
    jt_if.RegRs           = rs;
  endtask

  task automatic idle();
    jt_if.Valid_in        = 1'b0;
    jt_if.JumpType        = JT_NONE;
    jt_if.PCAddResult     = '0;
    jt_if.Instruction_idx = '0;
    jt_if.RegRs           = '0;
    jt_if.Stall           = 1'b0;
    jt_if.Flush           = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #12;
    checks++; if (jt_if.Address !== 32'h0) begin errors++; $display("FAIL rst_address: got %h want 00000000", jt_if.Address); end
    checks++; if (jt_if.Redirect !== 1'b0) begin errors++; $display("FAIL rst_redirect: got %b want 0", jt_if.Redirect); end
    checks++; if (jt_if.RASMispredict !== 1'b0) begin errors++; $display("FAIL rst_mispredict: got %b want 0", jt_if.RASMispredict); end
    checks++; if (jt_if.RASEmpty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b want 1", jt_if.RASEmpty); end
    checks++; if (jt_if.RASOverflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b want 0", jt_if.RASOverflow); end
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_j();
    drive(JT_J, 32'h4000_0010, 26'h000_0123, 32'h0);
    tick();
    idle();
    checks++; if (jt_if.Address !== 32'h4000_048C) begin errors++; $display("FAIL j_address: got %h want 4000048c", jt_if.Address); end
    checks++; if (jt_if.Redirect !== 1'b1) begin errors++; $display("FAIL j_redirect: got %b want 1", jt_if.Redirect); end
    checks++; if (jt_if.RASEmpty !== 1'b1) begin errors++; $display("FAIL j_empty: got %b want 1", jt_if.RASEmpty); end
    tick();
    checks++; if (jt_if.Redirect !== 1'b0) begin errors++; $display("FAIL j_redirect_pulse: got %b want 0", jt_if.Redirect); end
    checks++; if (jt_if.Address !== 32'h4000_048C) begin errors++; $display("FAIL j_address_hold: got %h want 4000048c", jt_if.Address); end
  endtask

  task automatic test_jal_jr();
    drive(JT_JAL, 32'h0040_0008, 26'h000_0010, 32'h0);
    tick();
    checks++; if (jt_if.Address !== 32'h0000_0040) begin errors++; $display("FAIL jal_address: got %h want 00000040", jt_if.Address); end
    checks++; if (jt_if.RASEmpty !== 1'b0) begin errors++; $display("FAIL jal_empty: got %b want 0", jt_if.RASEmpty); end
    drive(JT_JR, 32'h0, 26'h0, 32'h0040_0008);
    tick();
    idle();
    checks++; if (jt_if.Address !== 32'h0040_0008) begin errors++; $display("FAIL jr_address: got %h want 00400008", jt_if.Address); end
    checks++; if (jt_if.Redirect !== 1'b1) begin errors++; $display("FAIL jr_redirect: got %b want 1", jt_if.Redirect); end
    checks++; if (jt_if.RASMispredict !== 1'b0) begin errors++; $display("FAIL jr_mispredict: got %b want 0", jt_if.RASMispredict); end
    checks++; if (jt_if.RASEmpty !== 1'b1) begin errors++; $display("FAIL jr_empty: got %b want 1", jt_if.RASEmpty); end
    tick();
  endtask

  task automatic test_overflow();
    logic [31:0] pcs [5] = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h50};
    logic [31:0] rss [4] = '{32'h50, 32'h40, 32'h30, 32'h20};
    for (int i = 0; i < 5; i++) begin
      drive(JT_JAL, pcs[i], 26'h0, 32'h0);
      tick();
      if (i == 3) begin
        checks++; if (jt_if.RASOverflow !== 1'b0) begin errors++; $display("FAIL ovf_before_full: got %b want 0", jt_if.RASOverflow); end
      end
    end
    checks++; if (jt_if.RASOverflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", jt_if.RASOverflow); end
    for (int i = 0; i < 4; i++) begin
      drive(JT_JR, 32'h0, 26'h0, rss[i]);
      tick();
      checks++; if (jt_if.RASMispredict !== 1'b0) begin errors++; $display("FAIL ovf_pop%0d_mispredict: got %b want 0", i, jt_if.RASMispredict); end
      checks++; if (jt_if.Address !== rss[i]) begin errors++; $display("FAIL ovf_pop%0d_address: got %h want %h", i, jt_if.Address, rss[i]); end
    end
    checks++; if (jt_if.RASEmpty !== 1'b1) begin errors++; $display("FAIL ovf_drained_empty: got %b want 1", jt_if.RASEmpty); end
    drive(JT_JR, 32'h0, 26'h0, 32'h10);
    tick();
    idle();
    checks++; if (jt_if.RASMispredict !== 1'b1) begin errors++; $display("FAIL ovf_empty_jr_mispredict: got %b want 1", jt_if.RASMispredict); end
    checks++; if (jt_if.Address !== 32'h10) begin errors++; $display("FAIL ovf_empty_jr_address: got %h want 00000010", jt_if.Address); end
    checks++; if (jt_if.RASOverflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", jt_if.RASOverflow); end
    tick();
    checks++; if (jt_if.RASMispredict !== 1'b0) begin errors++; $display("FAIL ovf_mispredict_pulse: got %b want 0", jt_if.RASMispredict); end
  endtask

  task automatic test_mispredict();
    drive(JT_JAL, 32'h0040_0008, 26'h0, 32'h0);
    tick();
    drive(JT_JR, 32'h0, 26'h0, 32'h0000_1234);
    tick();
    idle();
    checks++; if (jt_if.Address !== 32'h0000_1234) begin errors++; $display("FAIL mp_address: got %h want 00001234", jt_if.Address); end
    checks++; if (jt_if.RASMispredict !== 1'b1) begin errors++; $display("FAIL mp_flag: got %b want 1", jt_if.RASMispredict); end
    checks++; if (jt_if.RASEmpty !== 1'b1) begin errors++; $display("FAIL mp_popped: got %b want 1", jt_if.RASEmpty); end
    tick();
  endtask

  task automatic test_stall_flush();
    drive(JT_JAL, 32'h0000_0100, 26'h0, 32'h0);
    jt_if.Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (jt_if.Redirect !== 1'b0) begin errors++; $display("FAIL stall%0d_redirect: got %b want 0", i, jt_if.Redirect); end
      checks++; if (jt_if.RASEmpty !== 1'b1) begin errors++; $display("FAIL stall%0d_no_push: got %b want 1", i, jt_if.RASEmpty); end
      checks++; if (jt_if.Address !== 32'h0000_1234) begin errors++; $display("FAIL stall%0d_address: got %h want 00001234", i, jt_if.Address); end
    end
    jt_if.Stall = 1'b0;
    tick();
    checks++; if (jt_if.Redirect !== 1'b1) begin errors++; $display("FAIL release_redirect: got %b want 1", jt_if.Redirect); end
    checks++; if (jt_if.RASEmpty !== 1'b0) begin errors++; $display("FAIL release_push: got %b want 0", jt_if.RASEmpty); end
    checks++; if (jt_if.Address !== 32'h0000_0000) begin errors++; $display("FAIL release_address: got %h want 00000000", jt_if.Address); end
    // A stall right after the accept must hold the pulse high.
    idle();
    jt_if.Stall = 1'b1;
    tick();
    checks++; if (jt_if.Redirect !== 1'b1) begin errors++; $display("FAIL stall_hold_redirect: got %b want 1", jt_if.Redirect); end
    jt_if.Stall = 1'b0;
    drive(JT_JAL, 32'h0000_0200, 26'h0, 32'h0);
    jt_if.Flush = 1'b1;
    tick();
    checks++; if (jt_if.Redirect !== 1'b0) begin errors++; $display("FAIL flush_redirect: got %b want 0", jt_if.Redirect); end
    jt_if.Flush = 1'b0;
    drive(JT_JR, 32'h0, 26'h0, 32'h0000_0100);
    tick();
    idle();
    checks++; if (jt_if.RASMispredict !== 1'b0) begin errors++; $display("FAIL flush_no_push_top: got %b want 0", jt_if.RASMispredict); end
    checks++; if (jt_if.RASEmpty !== 1'b1) begin errors++; $display("FAIL flush_no_push_empty: got %b want 1", jt_if.RASEmpty); end
    tick();
  endtask

  task automatic test_async_reset();
    drive(JT_JAL, 32'h0000_0300, 26'h0, 32'h0);
    tick();
    idle();
    checks++; if (jt_if.Redirect !== 1'b1) begin errors++; $display("FAIL areset_pre_redirect: got %b want 1", jt_if.Redirect); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (jt_if.Address !== 32'h0) begin errors++; $display("FAIL areset_address: got %h want 00000000", jt_if.Address); end
    checks++; if (jt_if.Redirect !== 1'b0) begin errors++; $display("FAIL areset_redirect: got %b want 0", jt_if.Redirect); end
    checks++; if (jt_if.RASEmpty !== 1'b1) begin errors++; $display("FAIL areset_empty: got %b want 1", jt_if.RASEmpty); end
    checks++; if (jt_if.RASOverflow !== 1'b0) begin errors++; $display("FAIL areset_overflow: got %b want 0", jt_if.RASOverflow); end
    #2 rst_n = 1'b1;
    tick();
    checks++; if (jt_if.Redirect !== 1'b0) begin errors++; $display("FAIL areset_after_redirect: got %b want 0", jt_if.Redirect); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_j();
    test_jal_jr();
    test_overflow();
    test_mispredict();
    test_stall_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_jump_target_unit
